// File: rtl/tsfm_pkg.sv
// TurboSound-FM write queue: shared entry type, control-byte layout,
// engine states and the FM register threshold.
package tsfm_pkg;

    typedef struct packed {
        logic       chip;
        logic       a0;
        logic [7:0] data;
    } entry_t;

    localparam logic [4:0] CTRL_PREFIX = 5'b11111;
    localparam int CTRL_SEL_BIT = 0;
    localparam int CTRL_FM_BIT = 2;

    localparam logic [7:0] FM_REG_MIN = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP,
        POLL
    } state_t;

endpackage

// File: rtl/tsfm_fifo.sv
// Show-ahead FIFO taking up to two pushes per cycle (port a first).
// Callers only push when there is room and only pop when non-empty.
module tsfm_fifo
    import tsfm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_a,
    input  entry_t                 din_a,
    input  logic                   push_b,
    input  entry_t                 din_b,
    input  logic                   pop,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    entry_t        mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [AW-1:0] slot_a;
    logic [AW-1:0] slot_b;

    assign slot_a = wr_ptr[AW-1:0];
    // the second push lands behind the first when both fire
    assign slot_b = slot_a + AW'(push_a);
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full = (level == ptr_t'(DEPTH));
    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_a) + ptr_t'(push_b);
            rd_ptr <= rd_ptr + ptr_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) mem[slot_a] <= din_a;
        if (push_b) mem[slot_b] <= din_b;
    end

endmodule

// File: rtl/tsfm_wr_queue.sv
// TurboSound-FM bus front end: decodes #FFFD/#BFFD writes, queues them
// and replays them into two jt03 cores with write gaps and busy polling.
module tsfm_wr_queue
    import tsfm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADDR_GAP = 2,
    parameter int SSG_GAP = 2,
    parameter int POLL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cpu_wr_addr,
    input  logic       cpu_wr_data,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_busy,
    output logic       ovf,
    output logic [1:0] ym_cs_n,
    output logic       ym_wr_n,
    output logic       ym_addr,
    output logic [7:0] ym_din,
    input  logic [7:0] ym_dout0,
    input  logic [7:0] ym_dout1,
    output logic       ay_mode
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = 16;
    typedef logic [LW-1:0] lvl_t;
    typedef logic [CW-1:0] cnt_t;

    state_t     state, state_nx;
    cnt_t       cnt, cnt_nx, gap_len;
    entry_t     cur, head, ent_a, ent_b;
    logic       chip_sel, fm_en, sel_now, is_ctrl;
    logic       cur_fm, chip_busy;
    logic [7:0] reg_latch [2];
    logic       push_a, push_b, take_a, take_b;
    logic       pop, full, empty;
    lvl_t       level, free;

    assign is_ctrl = cpu_wr_addr && (cpu_din[7:3] == CTRL_PREFIX);
    // a data pulse alongside a control write already uses the new chip
    assign sel_now = is_ctrl ? !cpu_din[CTRL_SEL_BIT] : chip_sel;
    assign push_a = cpu_wr_addr && !is_ctrl;
    assign push_b = cpu_wr_data;
    assign ent_a = '{chip: sel_now, a0: 1'b0, data: cpu_din};
    assign ent_b = '{chip: sel_now, a0: 1'b1, data: cpu_din};

    assign pop = (state == IDLE) && !empty;
    assign free = lvl_t'(DEPTH) - level + lvl_t'(pop);
    assign take_a = push_a && (!full || pop);
    assign take_b = push_b && (free > lvl_t'(take_a));

    tsfm_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_a (take_a),
        .din_a  (ent_a),
        .push_b (take_b),
        .din_b  (ent_b),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chip_sel <= 1'b0;
            fm_en <= 1'b1;
            ovf <= 1'b0;
        end else begin
            if (is_ctrl) begin
                chip_sel <= !cpu_din[CTRL_SEL_BIT];
                fm_en <= cpu_din[CTRL_FM_BIT];
            end
            if ((push_a && !take_a) || (push_b && !take_b))
                ovf <= 1'b1;
        end
    end

    assign chip_busy = cur.chip ? ym_dout1[7] : ym_dout0[7];
    assign gap_len = !cur.a0 ? cnt_t'(ADDR_GAP)
                   : cur_fm  ? cnt_t'(1)
                   :           cnt_t'(SSG_GAP);

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        unique case (state)
            IDLE: if (!empty) state_nx = SETUP;
            SETUP: if (cen) state_nx = STROBE;
            STROBE: if (cen) begin
                state_nx = GAP;
                cnt_nx = gap_len;
            end
            GAP: if (cen) begin
                if (cnt == cnt_t'(1)) begin
                    state_nx = cur_fm ? POLL : IDLE;
                    cnt_nx = cnt_t'(POLL_TIMEOUT);
                end else begin
                    cnt_nx = cnt - cnt_t'(1);
                end
            end
            POLL: if (cen) begin
                if (!chip_busy || cnt == cnt_t'(1))
                    state_nx = IDLE;
                else
                    cnt_nx = cnt - cnt_t'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            cur <= '0;
            cur_fm <= 1'b0;
            reg_latch[0] <= '0;
            reg_latch[1] <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (pop) begin
                cur <= head;
                cur_fm <= head.a0 && fm_en
                       && (reg_latch[head.chip] >= FM_REG_MIN);
            end
            if (state == STROBE && cen && !cur.a0)
                reg_latch[cur.chip] <= cur.data;
        end
    end

    always_comb begin
        ym_cs_n = 2'b11;
        ym_wr_n = 1'b1;
        ym_addr = cur.a0;
        ym_din = cur.data;
        if (state == STROBE) begin
            ym_cs_n[cur.chip] = 1'b0;
            ym_wr_n = 1'b0;
        end
        if (state == POLL) begin
            ym_cs_n[cur.chip] = 1'b0;
            ym_addr = 1'b0;
        end
    end

    assign cpu_busy = !empty || (state != IDLE);
    assign cpu_dout = chip_sel ? ym_dout1 : ym_dout0;
    assign ay_mode = !fm_en;

endmodule

// File: tb/tb_tsfm_wr_queue.sv
// Scoreboard bench for tsfm_wr_queue: directed scenarios, then random
// traffic checked against an in-order queue model of chip bus writes.
`timescale 1ns/1ps
module tb_tsfm_wr_queue;
    import tsfm_pkg::*;

    localparam int DEPTH = 8;
    localparam int ADDR_GAP = 2;
    localparam int SSG_GAP = 2;
    localparam int POLL_TIMEOUT = 255;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       cen = 0;
    logic       cpu_wr_addr = 0;
    logic       cpu_wr_data = 0;
    logic [7:0] cpu_din = 0;
    logic [7:0] cpu_dout;
    logic       cpu_busy, ovf, ym_wr_n, ym_addr, ay_mode;
    logic [1:0] ym_cs_n;
    logic [7:0] ym_din;
    logic [7:0] ym_dout0 = 8'h15;
    logic [7:0] ym_dout1 = 8'h6A;

    tsfm_wr_queue #(
        .DEPTH(DEPTH),
        .ADDR_GAP(ADDR_GAP),
        .SSG_GAP(SSG_GAP),
        .POLL_TIMEOUT(POLL_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_busy    (cpu_busy),
        .ovf         (ovf),
        .ym_cs_n     (ym_cs_n),
        .ym_wr_n     (ym_wr_n),
        .ym_addr     (ym_addr),
        .ym_din      (ym_din),
        .ym_dout0    (ym_dout0),
        .ym_dout1    (ym_dout1),
        .ay_mode     (ay_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       chip;
        logic       a0;
        logic [7:0] data;
        logic       fm;
    } exp_t;

    exp_t       expq[$];
    logic       m_sel = 0;
    logic       m_fm_en = 1;
    logic [7:0] m_latch [2] = '{8'h00, 8'h00};

    int vectors = 0;
    int miscompares = 0;
    int cen_ticks = 0;
    int poll_ticks = 0;
    int strobes = 0;
    int cur_poll = 0;
    int last_tick = 0;
    int prev_tick = 0;
    logic prev_fm = 0;
    logic prev_chip = 0;
    int cen_mode = 0;
    int cen_ph = 0;
    int hold [2] = '{0, 0};
    int hold_cfg = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // chip clock enable: off, every 4th clk, or random ~1/3
    initial forever begin
        @(posedge clk);
        #1;
        cen_ph = (cen_ph + 1) % 4;
        case (cen_mode)
            1: cen = (cen_ph == 0);
            2: cen = ($urandom % 3) == 0;
            default: cen = 0;
        endcase
    end

    always @(posedge clk) if (cen) cen_ticks++;

    // chip busy model: bit 7 stays set for hold[c] polled ticks
    initial begin
        logic [1:0] dec;
        forever begin
            @(negedge clk);
            dec = 2'b00;
            for (int c = 0; c < 2; c++)
                if (cen && ym_wr_n && !ym_cs_n[c]) dec[c] = 1'b1;
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++)
                if (dec[c] && hold[c] > 0) hold[c]--;
            ym_dout0 = {hold[0] > 0, 7'h15};
            ym_dout1 = {hold[1] > 0, 7'h6A};
        end
    end

    // monitor: every cen-qualified strobe is a chip write
    initial begin
        exp_t e;
        int c;
        forever begin
            @(negedge clk);
            if (rst_n && cen && ym_wr_n && ym_cs_n != 2'b11) begin
                poll_ticks++;
                cur_poll++;
                chk("poll_cs", ym_cs_n, prev_chip ? 2'b01 : 2'b10);
                chk("poll_a0", ym_addr, 0);
            end
            if (rst_n && cen && !ym_wr_n) begin
                chk("poll_seen", cur_poll > 0, prev_fm);
                c = (ym_cs_n == 2'b10) ? 0 : (ym_cs_n == 2'b01) ? 1 : -1;
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got cs %b data %0h expected none",
                             ym_cs_n, ym_din);
                end else begin
                    e = expq.pop_front();
                    chk("wr_chip", c, e.chip);
                    chk("wr_a0", ym_addr, e.a0);
                    chk("wr_data", ym_din, e.data);
                    prev_fm = e.fm;
                    prev_chip = e.chip;
                    if (e.a0)
                        hold[e.chip] = (hold_cfg >= 0) ? hold_cfg
                                     : int'($urandom_range(0, 6));
                end
                cur_poll = 0;
                strobes++;
                prev_tick = last_tick;
                last_tick = cen_ticks + 1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input logic a0, input logic [7:0] v);
        exp_t e;
        if (!a0) m_latch[m_sel] = v;
        e.chip = m_sel;
        e.a0 = a0;
        e.data = v;
        e.fm = a0 && m_fm_en && (m_latch[m_sel] >= 8'h10);
        expq.push_back(e);
    endtask

    task automatic push(input logic do_a, input logic do_d,
                        input logic [7:0] v, input int accept);
        cpu_wr_addr = do_a;
        cpu_wr_data = do_d;
        cpu_din = v;
        if (do_a && accept > 0) model_add(1'b0, v);
        if (do_d && accept > (do_a ? 1 : 0)) model_add(1'b1, v);
        cycle();
        cpu_wr_addr = 0;
        cpu_wr_data = 0;
    endtask

    task automatic ctrl(input logic [7:0] v);
        cpu_wr_addr = 1;
        cpu_din = v;
        m_sel = !v[0];
        m_fm_en = v[2];
        cycle();
        cpu_wr_addr = 0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!cpu_busy) return;
        end
        chk(name, cpu_busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, ok;
        logic [7:0] v;
        int r;

        repeat (3) cycle();
        chk("rst_cs_n", ym_cs_n, 2'b11);
        chk("rst_wr_n", ym_wr_n, 1);
        chk("rst_addr", ym_addr, 0);
        chk("rst_din", ym_din, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_ay", ay_mode, 0);
        chk("rst_dout", cpu_dout, 8'h15);
        rst_n = 1;
        cen_mode = 1;
        repeat (2) cycle();

        // SSG address then data on chip 0
        p0 = poll_ticks;
        s0 = strobes;
        push(1, 0, 8'h07, 2);
        chk("busy_rise", cpu_busy, 1);
        push(0, 1, 8'h3E, 2);
        wait_idle(300, "t1_idle");
        chk("t1_strobes", strobes - s0, 2);
        chk("t1_addr_gap", last_tick - prev_tick, ADDR_GAP + 2);
        chk("t1_busy_fall", cen_ticks - last_tick, SSG_GAP);
        chk("t1_no_poll", poll_ticks - p0, 0);

        // FM write on chip 1, busy for 10 polled ticks
        ctrl(8'hFE);
        chk("t2_dout", cpu_dout, 8'h6A);
        hold_cfg = 10;
        p0 = poll_ticks;
        push(1, 0, 8'h28, 2);
        push(0, 1, 8'hF0, 2);
        wait_idle(500, "t2_idle");
        chk("t2_poll_len", poll_ticks - p0, 11);

        // chip 0 stuck busy: poll times out
        ctrl(8'hFD);
        chk("t3_dout", cpu_dout, 8'h15);
        hold_cfg = 100000;
        p0 = poll_ticks;
        push(1, 0, 8'h28, 2);
        push(0, 1, 8'hAA, 2);
        wait_idle(3000, "t3_idle");
        chk("t3_timeout", poll_ticks - p0, POLL_TIMEOUT);
        hold[0] = 0;

        // fm_en off: FM register write uses the SSG gap, no poll
        ctrl(8'hFB);
        chk("t4_ay_mode", ay_mode, 1);
        hold_cfg = 50;
        p0 = poll_ticks;
        push(1, 0, 8'h28, 2);
        push(0, 1, 8'h55, 2);
        wait_idle(300, "t4_idle");
        chk("t4_no_poll", poll_ticks - p0, 0);
        chk("t4_ssg_gap", cen_ticks - last_tick, SSG_GAP);
        hold[0] = 0;
        hold_cfg = 0;

        // overflow with the chip clock stopped
        cen_mode = 0;
        repeat (3) cycle();
        s0 = strobes;
        push(0, 1, 8'h01, 1);
        repeat (3) cycle();
        for (int i = 0; i < 10; i++)
            push(0, 1, 8'h40 + 8'(i), (i < DEPTH) ? 1 : 0);
        cycle();
        chk("t5_ovf", ovf, 1);
        chk("t5_busy", cpu_busy, 1);
        chk("t5_stalled", strobes - s0, 0);
        cen_mode = 1;
        wait_idle(800, "t5_idle");
        chk("t5_issued", strobes - s0, DEPTH + 1);
        chk("t5_drained", expq.size(), 0);

        // reset in the middle of a strobe
        push(0, 1, 8'h61, 2);
        push(0, 1, 8'h62, 2);
        push(0, 1, 8'h63, 2);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!ym_wr_n && !cen) begin
                ok = 1;
                break;
            end
        end
        chk("t6_strobe_seen", ok, 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_cs_n", ym_cs_n, 2'b11);
        chk("t6_wr_n", ym_wr_n, 1);
        chk("t6_ovf", ovf, 0);
        chk("t6_busy", cpu_busy, 0);
        expq.delete();
        m_sel = 0;
        m_fm_en = 1;
        m_latch[0] = 8'h00;
        m_latch[1] = 8'h00;
        prev_fm = 0;
        cur_poll = 0;
        hold[0] = 0;
        hold[1] = 0;
        repeat (2) cycle();
        chk("t6_ay", ay_mode, 0);
        rst_n = 1;
        cycle();

        // random traffic against the queue model
        cen_mode = 2;
        hold_cfg = -1;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom % 10);
            if (r < 2) begin
                cycle();
            end else if (r == 9) begin
                if (expq.size() == 0) begin
                    v = 8'($urandom);
                    ctrl({5'b11111, v[2:0]});
                end else begin
                    cycle();
                end
            end else begin
                ok = 0;
                for (int i = 0; i < 3000; i++) begin
                    if (expq.size() + 2 <= DEPTH) begin
                        ok = 1;
                        break;
                    end
                    cycle();
                end
                if (ok == 0) begin
                    chk("rand_room", expq.size() + 2 <= DEPTH, 1);
                    break;
                end
                v = 8'($urandom_range(0, 8'hF7));
                case (r % 3)
                    0: push(1, 0, v, 2);
                    1: push(0, 1, v, 2);
                    default: push(1, 1, v, 2);
                endcase
            end
        end
        wait_idle(5000, "rand_idle");
        chk("rand_last_poll", cur_poll > 0, prev_fm);
        chk("rand_drained", expq.size(), 0);
        chk("rand_no_ovf", ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tsfm_wr_queue.md
# tsfm_wr_queue

TurboSound-FM bus front end: decodes CPU writes to ports #FFFD/#BFFD, queues them, and replays them into two jt03 (YM2203) instances at chip-safe pace. It applies address/data write gaps and busy-flag polling after FM data writes. It sits between the Z80 I/O decoder and the two jt03 cores. It also muxes chip read data back to the CPU.

## Interface
- `DEPTH`, 8: queue entries (power of 2, ≥2)
- `ADDR_GAP`, 2: cen ticks idle after an address write
- `SSG_GAP`, 2: cen ticks idle after an SSG (reg < #10) data write
- `POLL_TIMEOUT`, 255: max cen ticks in busy poll before forced exit

- `clk`  in  1  system clock, same as jt03
- `rst_n`  in  1  asynchronous, active-low reset
- `cen`  in  1  chip clock enable, same strobe fed to both jt03
- `cpu_wr_addr`  in  1  one-cycle write pulse, port #FFFD
- `cpu_wr_data`  in  1  one-cycle write pulse, port #BFFD
- `cpu_din`  in  8  CPU write data
- `cpu_dout`  out  8  read data: `ym_dout0` if chip_sel=0 else `ym_dout1`
- `cpu_busy`  out  1  queue non-empty or engine not IDLE
- `ovf`  out  1  sticky: a write was dropped on full; cleared by reset only
- `ym_cs_n`  out  2  per-chip chip select, active low
- `ym_wr_n`  out  1  shared write strobe
- `ym_addr`  out  1  shared A0 (0 = address, 1 = data)
- `ym_din`  out  8  shared write data
- `ym_dout0`, `ym_dout1`  in  8  chip read data
- `ay_mode`  out  1  = ~fm_en, to both jt03

## Operation
- Control write: `cpu_wr_addr` with `cpu_din[7:3]==5'b11111`. It is not queued and takes effect in the same cycle.
  - Bit0: 1 selects chip 0, 0 selects chip 1; this sets chip_sel.
  - Bit2: fm_en.
  - Bits 1 and 7:3 are ignored.
- All other `cpu_wr_addr`/`cpu_wr_data` pulses enqueue {chip_sel, a0, data}. The entry is tagged with chip_sel at enqueue time.
- Full queue: the write is dropped, `ovf` sets, and queue contents are unchanged.
- The engine keeps `reg_latch[chip]`, updated when an address write issues. An FM data write is a data write with `reg_latch[chip] >= #10` and fm_en=1.
- States:
  - IDLE: if the queue is non-empty, pop the entry, drive `ym_addr`/`ym_din`, and go to SETUP.
  - SETUP: outputs stable with all cs_n high. On the next cen cycle, go to STROBE.
  - STROBE: selected `ym_cs_n` and `ym_wr_n` low. They stay low through exactly one cen-qualified cycle, then go to GAP.
  - GAP: counts cen ticks. The count is ADDR_GAP for an address write, SSG_GAP for an SSG data write, and 1 for an FM data write. Then go to POLL for an FM data write, otherwise IDLE.
  - POLL: selected cs_n low, wr_n high, `ym_addr`=0. Sample selected `ym_doutN[7]` on each cen cycle.
    - Bit 7 = 0: go to IDLE.
    - POLL_TIMEOUT ticks elapsed: go to IDLE.
- Reads never stall. `cpu_dout` is combinational from the current chip_sel.
- Reset values:
  - Outputs: `ym_cs_n`=2'b11, `ym_wr_n`=1, `ym_addr`=0, `ym_din`=0, `ovf`=0, `cpu_busy`=0, `ay_mode`=0.
  - Internal: chip_sel=0, fm_en=1, `reg_latch`=0, queue empty, state IDLE.

## Timing
- Enqueue is visible in the level count on the cycle after the pulse. `cpu_busy` rises the cycle after the pulse.
- Minimum pop-to-strobe: SETUP lasts until the first cen after entry (≥1 clk).
- Strobe width is exactly 1 cen period; `ym_din`/`ym_addr` stay stable from SETUP until GAP exit.
- Simultaneous push and pop on a full queue: pop first, push accepted, no `ovf`.
- Simultaneous `cpu_wr_addr` and `cpu_wr_data`: address enqueued first, data second. If only one slot is free, the data write is dropped and `ovf` sets.
- A control write while the engine is mid-transaction affects only later enqueues.
- Reset mid-transaction: cs_n/wr_n release asynchronously and the queue is flushed.
- Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.

## Structure
- Package `tsfm_pkg`:
  - entry struct {chip, a0, data}
  - control-byte constants (prefix 5'b11111, bit positions)
  - state enum {IDLE, SETUP, STROBE, GAP, POLL}
  - FM register threshold #10
- Sub-module `tsfm_fifo`: synchronous FIFO of DEPTH entries with push, pop, full, empty and level.
- The engine FSM and decode stay in top level.

## Test plan
- Write #FFFD=#07 then #BFFD=#3E with cen every 4 clk. Chip 0 sees an address strobe with A0=0/#07, then at least 2 cen later a data strobe with A0=1/#3E. No POLL occurs, and `cpu_busy` falls after the last GAP.
- Write #FFFD=#FE, then #28 address and #F0 data. Writes go to `ym_cs_n[1]`. After the data strobe, the engine enters POLL. With `ym_dout1[7]` held 1 for 10 cen, exit occurs on the first cen where it reads 0.
- With `ym_dout0[7]` stuck at 1 after an FM data write, POLL exits after exactly 255 cen ticks.
- Write #FFFD=#FB (fm_en=0), then reg #28 with data. `ay_mode`=1, no POLL occurs, and SSG_GAP applies.
- Make 10 back-to-back writes with cen=0 and DEPTH=8. Eight are queued and two dropped, `ovf`=1; after cen resumes, the eight issue in order.
- Assert `rst_n` low during STROBE. `ym_cs_n`=11 and `ym_wr_n`=1 immediately (asynchronously), the queue is empty, and `ovf`=0.
